// File: rtl/text_box_scheduler.sv
// Text overlay controller: collects a string into a shadow buffer over a
// valid/ready port, publishes it to the overlay on the next new-frame pulse,
// and bounces the text box around the active area one step per frame.
module text_box_scheduler #(
   parameter int COLUMNS  = 13,
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 720,
   parameter int BOX_W    = 104,
   parameter int BOX_H    = 16,
   parameter int X_INIT   = 100,
   parameter int Y_INIT   = 100,
   parameter int STEP_X   = 2,
   parameter int STEP_Y   = 1,
   parameter int X_W      = 11,
   parameter int Y_W      = 10
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_nf,
   input  logic                       i_run,
   input  logic                       i_wr_valid,
   output logic                       o_wr_ready,
   input  logic [$clog2(COLUMNS)-1:0] i_wr_index,
   input  logic [7:0]                 i_wr_char,
   input  logic                       i_wr_last,
   output logic [COLUMNS*8-1:0]       o_characters,
   output logic [X_W-1:0]             o_x,
   output logic [Y_W-1:0]             o_y,
   output logic                       o_en,
   output logic                       o_pending
);

   localparam logic [COLUMNS*8-1:0] BLANK = {COLUMNS{8'h20}};

   // Motion limits and steps, widened by one bit so the overshoot test cannot wrap.
   localparam logic [X_W:0]   X_MAX    = (X_W+1)'(H_ACTIVE - BOX_W);
   localparam logic [X_W:0]   X_STEP   = (X_W+1)'(STEP_X);
   localparam logic [X_W-1:0] X_STEP_N = X_W'(STEP_X);
   localparam logic [Y_W:0]   Y_MAX    = (Y_W+1)'(V_ACTIVE - BOX_H);
   localparam logic [Y_W:0]   Y_STEP   = (Y_W+1)'(STEP_Y);
   localparam logic [Y_W-1:0] Y_STEP_N = Y_W'(STEP_Y);

   typedef enum logic {FILL, PEND} state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic                   commit;
   logic                   hs;
   logic [COLUMNS*8-1:0]   shadow;

   logic                   dir_x;
   logic                   dir_y;
   logic [X_W-1:0]         x_nxt;
   logic [Y_W-1:0]         y_nxt;
   logic                   dir_x_nxt;
   logic                   dir_y_nxt;
   logic [X_W:0]           x_ext;
   logic [X_W:0]           x_sum;
   logic [Y_W:0]           y_ext;
   logic [Y_W:0]           y_sum;

   // Ready is only ever high in FILL, so a handshake implies FILL.
   assign hs = i_wr_valid & o_wr_ready;

   // Next-state: the last character arms a commit; the next frame pulse performs it.
   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      case (state)
         FILL: begin
            if (hs && i_wr_last) state_nxt = PEND;
         end
         PEND: begin
            if (i_nf) begin
               state_nxt = FILL;
               commit    = 1'b1;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= FILL;
      else       state <= state_nxt;
   end

   // Horizontal bounce: clamp to the edge on overshoot and reverse.
   always_comb begin
      x_ext     = {1'b0, o_x};
      x_sum     = x_ext + X_STEP;
      x_nxt     = o_x;
      dir_x_nxt = dir_x;
      if (dir_x) begin
         if (x_sum > X_MAX) begin
            x_nxt     = X_MAX[X_W-1:0];
            dir_x_nxt = 1'b0;
         end else begin
            x_nxt     = x_sum[X_W-1:0];
         end
      end else begin
         if (x_ext < X_STEP) begin
            x_nxt     = '0;
            dir_x_nxt = 1'b1;
         end else begin
            x_nxt     = o_x - X_STEP_N;
         end
      end
   end

   // Vertical bounce, same rule as horizontal.
   always_comb begin
      y_ext     = {1'b0, o_y};
      y_sum     = y_ext + Y_STEP;
      y_nxt     = o_y;
      dir_y_nxt = dir_y;
      if (dir_y) begin
         if (y_sum > Y_MAX) begin
            y_nxt     = Y_MAX[Y_W-1:0];
            dir_y_nxt = 1'b0;
         end else begin
            y_nxt     = y_sum[Y_W-1:0];
         end
      end else begin
         if (y_ext < Y_STEP) begin
            y_nxt     = '0;
            dir_y_nxt = 1'b1;
         end else begin
            y_nxt     = o_y - Y_STEP_N;
         end
      end
   end

   // Handshake flags track the upcoming state so they line up with it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_wr_ready <= 1'b0;
         o_pending  <= 1'b0;
      end else begin
         o_wr_ready <= (state_nxt == FILL);
         o_pending  <= (state_nxt == PEND);
      end
   end

   // Shadow buffer: out-of-range columns are accepted but discarded.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         shadow <= BLANK;
      end else if (hs && (int'(i_wr_index) < COLUMNS)) begin
         shadow[int'(i_wr_index)*8 +: 8] <= i_wr_char;
      end
   end

   // Displayed string and enable change only on a frame boundary.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_characters <= BLANK;
         o_en         <= 1'b0;
      end else if (commit) begin
         o_characters <= shadow;
         o_en         <= 1'b1;
      end
   end

   // Box position steps once per frame while running.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_x   <= X_W'(X_INIT);
         o_y   <= Y_W'(Y_INIT);
         dir_x <= 1'b1;
         dir_y <= 1'b1;
      end else if (i_nf && i_run) begin
         o_x   <= x_nxt;
         o_y   <= y_nxt;
         dir_x <= dir_x_nxt;
         dir_y <= dir_y_nxt;
      end
   end

endmodule

// File: tb/tb_text_box_scheduler.sv
// Directed testbench for text_box_scheduler.
module tb_text_box_scheduler;

   localparam int COLUMNS = 13;
   localparam int CW      = COLUMNS*8;

   logic          clk = 1'b0;
   logic          rst;
   logic          nf;
   logic          run;
   logic          wr_valid;
   logic          wr_ready;
   logic [3:0]    wr_index;
   logic [7:0]    wr_char;
   logic          wr_last;
   logic [CW-1:0] characters;
   logic [10:0]   x;
   logic [9:0]    y;
   logic          en;
   logic          pending;

   int tests = 0;
   int fails = 0;

   text_box_scheduler dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_nf         (nf),
      .i_run        (run),
      .i_wr_valid   (wr_valid),
      .o_wr_ready   (wr_ready),
      .i_wr_index   (wr_index),
      .i_wr_char    (wr_char),
      .i_wr_last    (wr_last),
      .o_characters (characters),
      .o_x          (x),
      .o_y          (y),
      .o_en         (en),
      .o_pending    (pending)
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] pack(input string s);
      logic [CW-1:0] v;
      v = {COLUMNS{8'h20}};
      for (int i = 0; i < s.len() && i < COLUMNS; i++) v[i*8 +: 8] = s[i];
      return v;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_char(input logic [3:0] idx, input logic [7:0] ch, input logic last);
      wr_valid = 1'b1;
      wr_index = idx;
      wr_char  = ch;
      wr_last  = last;
      tick();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
   endtask

   task automatic nf_pulse();
      nf = 1'b1;
      tick();
      nf = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         nf_pulse();
         tick();
      end
   endtask

   initial begin
      string hello;
      hello    = "Hello, world!";
      rst      = 1'b0;
      nf       = 1'b0;
      run      = 1'b0;
      wr_valid = 1'b0;
      wr_index = '0;
      wr_char  = '0;
      wr_last  = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1. reset state and release
      check("rst_en",      en,         0);
      check("rst_x",       x,          100);
      check("rst_y",       y,          100);
      check("rst_chars",   characters, pack(""));
      check("rst_pending", pending,    0);
      check("rst_ready",   wr_ready,   0);
      rst = 1'b0;
      #1;
      check("rel_ready_before_edge", wr_ready, 0);
      tick();
      check("rel_ready_after_edge", wr_ready, 1);

      // 2. write and commit a full string
      for (int i = 0; i < COLUMNS; i++) write_char(4'(i), hello[i], i == COLUMNS-1);
      check("wr_pending",     pending,    1);
      check("wr_ready_low",   wr_ready,   0);
      check("wr_chars_hold",  characters, pack(""));
      check("wr_en_low",      en,         0);
      tick();
      tick();
      check("wr_still_pend",  pending,    1);
      nf_pulse();
      check("cm_chars",       characters, pack("Hello, world!"));
      check("cm_en",          en,         1);
      check("cm_pending",     pending,    0);
      check("cm_ready",       wr_ready,   1);

      // 3. bouncing motion
      run = 1'b1;
      frames(538);
      check("f538_x", x, 1176);
      check("f538_y", y, 638);
      frames(1);
      check("f539_x", x, 1176);
      check("f539_y", y, 639);
      frames(1);
      check("f540_x", x, 1174);
      check("f540_y", y, 640);
      frames(60);
      check("f600_x", x, 1054);
      check("f600_y", y, 700);
      frames(4);
      check("f604_x", x, 1046);
      check("f604_y", y, 704);
      frames(1);
      check("f605_x", x, 1044);
      check("f605_y", y, 704);
      frames(1);
      check("f606_x", x, 1042);
      check("f606_y", y, 703);
      frames(521);
      check("f1127_x", x, 0);
      check("f1127_y", y, 182);
      frames(1);
      check("f1128_x", x, 0);
      check("f1128_y", y, 181);
      frames(1);
      check("f1129_x", x, 2);
      check("f1129_y", y, 180);
      check("run_chars_kept", characters, pack("Hello, world!"));
      run = 1'b0;

      // 4. last handshake coincident with a frame pulse
      write_char(4'd0, "A", 1'b0);
      write_char(4'd1, "B", 1'b0);
      nf = 1'b1;
      write_char(4'd2, "C", 1'b1);
      nf = 1'b0;
      check("coin_pending",   pending,    1);
      check("coin_no_commit", characters, pack("Hello, world!"));
      check("coin_en",        en,         1);
      nf_pulse();
      check("coin_commit",    characters, pack("ABClo, world!"));
      check("coin_pend_clr",  pending,    0);
      check("coin_ready",     wr_ready,   1);

      // 5. out-of-range column, then frozen position
      write_char(4'd13, "Z", 1'b1);
      check("oor_pending", pending, 1);
      nf_pulse();
      check("oor_chars",   characters, pack("ABClo, world!"));
      check("oor_pend_clr", pending,   0);
      frames(10);
      check("frz_x", x, 2);
      check("frz_y", y, 180);

      // 6. reset while a commit is pending
      write_char(4'd0, "Q", 1'b1);
      check("p6_pending", pending, 1);
      #2 rst = 1'b1;
      #1;
      check("ar_chars",   characters, pack(""));
      check("ar_x",       x,          100);
      check("ar_y",       y,          100);
      check("ar_en",      en,         0);
      check("ar_pending", pending,    0);
      check("ar_ready",   wr_ready,   0);
      tick();
      rst = 1'b0;
      tick();
      check("ar_rel_ready", wr_ready, 1);
      nf_pulse();
      check("ar_no_commit", characters, pack(""));
      check("ar_en_low",    en,         0);
      write_char(4'd0, "K", 1'b1);
      nf_pulse();
      check("ar_fresh_chars", characters, pack("K"));
      check("ar_fresh_en",    en,         1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
